urv_imem_arb: RTL and testbench

Two-requester arbiter for the single-port synchronous instruction RAM behind the uRV fetch stage. It shares the RAM between the core fetch port and a host port. The host port is the UART/Ethernet bootloader or debug master, and it can read and write RAM words. Fetch has priority. A starvation counter guarantees the host a slot within a bounded number of cycles. While the core is halted, the host gets full bandwidth.

---
 rtl/urv_defs.sv | 11 +
 rtl/urv_imem_arb.sv | 118 +++++++++++
 tb/tb_urv_imem_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/urv_defs.sv
// Shared definitions for the uRV instruction-memory arbiter.
package urv_defs;

    // Each state records which requester held the RAM port in the previous cycle.
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOST  = 1'b1;

    // Byte address at which the instruction RAM is mapped.
    localparam logic [31:0] START_ADDR = 32'h0000_0000;

endpackage

// File: rtl/urv_imem_arb.sv
// Arbiter that shares the single-port instruction RAM between the core fetch
// port and the host (bootloader/debug) port.
//
// state   | meaning
// S_FETCH | previous cycle granted fetch (or nothing since reset)
// S_HOST  | previous cycle granted host; its ack is due this cycle
//
// Fetch has priority. run_cnt counts consecutive fetch grants, and a pending
// host request wins once FETCH_RUN fetch grants have been made. While the core
// is halted, the host may take every cycle.
module urv_imem_arb
    import urv_defs::*;
#(
    parameter int MEM_AW    = 14,
    parameter int FETCH_RUN = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              core_halt_i,
    input  logic [31:0]       im_addr_i,
    output logic [31:0]       im_data_o,
    output logic              im_valid_o,
    input  logic              h_req_i,
    input  logic              h_we_i,
    input  logic [31:0]       h_addr_i,
    input  logic [31:0]       h_wdata_i,
    input  logic [3:0]        h_be_i,
    output logic              h_ack_o,
    output logic [31:0]       h_rdata_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_we_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] RUN_MAX = 4'(FETCH_RUN);

    logic [0:0]  state;
    logic [3:0]  run_cnt;
    logic        host_en;
    logic        h_grant;
    logic [31:0] im_off;
    logic [31:0] h_off;
    logic [31:0] h_rdata_q;
    logic        unused_addr_bits;

    // Only the word-index bits reach the RAM, so addresses wrap modulo its size.
    assign im_off           = im_addr_i - START_ADDR;
    assign h_off            = h_addr_i - START_ADDR;
    assign unused_addr_bits = ^{im_off[31:MEM_AW+2], im_off[1:0],
                                h_off[31:MEM_AW+2], h_off[1:0]};

    // Host grant. host_en is cleared asynchronously by reset, so an access that
    // is in progress when reset arrives never writes the RAM and never acks.
    always_comb begin
        h_grant = 1'b0;
        if (host_en && h_req_i) begin
            if (core_halt_i) begin
                h_grant = 1'b1;
            end else if (state == S_FETCH && run_cnt == RUN_MAX) begin
                h_grant = 1'b1;
            end
        end
    end

    // Track the previous grant and the saturating fetch-run counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_FETCH;
            run_cnt <= RUN_MAX;
            host_en <= 1'b0;
        end else begin
            host_en <= 1'b1;
            if (h_grant) begin
                state   <= S_HOST;
                run_cnt <= '0;
            end else begin
                state <= S_FETCH;
                if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + 4'd1;
                end
            end
        end
    end

    // Steer the RAM port to whichever requester won this cycle.
    always_comb begin
        mem_addr_o  = im_off[MEM_AW+1:2];
        mem_wdata_o = h_wdata_i;
        mem_we_o    = '0;
        if (h_grant) begin
            mem_addr_o = h_off[MEM_AW+1:2];
            if (h_we_i) begin
                mem_we_o = h_be_i;
            end
        end
    end

    // One-cycle response flags; host read data is captured with the ack and held.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            im_valid_o <= 1'b0;
            h_ack_o    <= 1'b0;
            h_rdata_q  <= '0;
        end else begin
            im_valid_o <= !h_grant && !core_halt_i;
            h_ack_o    <= h_grant;
            if (h_ack_o) begin
                h_rdata_q <= mem_rdata_i;
            end
        end
    end

    // Both ports see the RAM output directly during their response cycle.
    assign im_data_o = mem_rdata_i;
    assign h_rdata_o = h_ack_o ? mem_rdata_i : h_rdata_q;

endmodule

// File: tb/tb_urv_imem_arb.sv
// Directed bench for urv_imem_arb with a behavioural single-port RAM.
module tb_urv_imem_arb;

    localparam int MEM_AW    = 14;
    localparam int FETCH_RUN = 4;

    logic              clk;
    logic              rst_n;
    logic              core_halt;
    logic [31:0]       im_addr;
    logic [31:0]       im_data;
    logic              im_valid;
    logic              h_req;
    logic              h_we;
    logic [31:0]       h_addr;
    logic [31:0]       h_wdata;
    logic [3:0]        h_be;
    logic              h_ack;
    logic [31:0]       h_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_we;
    logic [31:0]       ram_q;

    logic [31:0] ram [0:(1<<MEM_AW)-1];

    int vectors     = 0;
    int miscompares = 0;

    urv_imem_arb #(.MEM_AW(MEM_AW), .FETCH_RUN(FETCH_RUN)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .core_halt_i (core_halt),
        .im_addr_i   (im_addr),
        .im_data_o   (im_data),
        .im_valid_o  (im_valid),
        .h_req_i     (h_req),
        .h_we_i      (h_we),
        .h_addr_i    (h_addr),
        .h_wdata_i   (h_wdata),
        .h_be_i      (h_be),
        .h_ack_o     (h_ack),
        .h_rdata_o   (h_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM, read-before-write, byte write enables.
    always @(posedge clk) begin
        ram_q <= ram[mem_addr];
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] pat(input int i);
        logic [15:0] w;
        w = i[15:0];
        return {w ^ 16'hA5A5, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old8;
        logic [32:0] wide_addr;

        for (int i = 0; i < (1 << MEM_AW); i++) ram[i] = pat(i);

        // Held in reset with a host write pending; nothing may reach the RAM.
        rst_n = 1'b0; core_halt = 1'b0; im_addr = 32'h0;
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h0; h_wdata = 32'h0; h_be = 4'hF;
        step();
        chk("rst_im_valid", im_valid, 0);
        chk("rst_h_ack",    h_ack,    0);
        chk("rst_h_rdata",  h_rdata,  0);
        chk("rst_mem_we",   mem_we,   0);
        h_req = 1'b0; h_we = 1'b0;
        #1 rst_n = 1'b1;

        // 1: fetch stream after reset
        step();
        chk("t1_valid0", im_valid, 1);
        chk("t1_data0",  im_data,  pat(0));
        im_addr = 32'h4;
        step();
        chk("t1_data1", im_data, pat(1));
        im_addr = 32'h8;
        step();
        chk("t1_data2", im_data, pat(2));

        // 3: idle host gets the very next slot, partial write
        im_addr = 32'hC;
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h20; h_wdata = 32'hDEAD_BEEF; h_be = 4'b0011;
        #1;
        chk("t3_mem_we",    mem_we,    4'b0011);
        chk("t3_mem_addr",  mem_addr,  14'h8);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("t3_ack",    h_ack,    1);
        chk("t3_valid",  im_valid, 0);
        chk("t3_rdata",  h_rdata,  pat(8));

        // 2: host read pending with no credit, four fetches then the host
        h_we = 1'b0; h_be = 4'h0; h_addr = 32'h100;
        #1;
        chk("t2_fetch_addr", mem_addr, 14'h3);
        chk("t2_fetch_we",   mem_we,   0);
        step();
        chk("t2_f1_ack",   h_ack,    0);
        chk("t2_f1_valid", im_valid, 1);
        chk("t2_f1_data",  im_data,  pat(3));
        chk("t2_held_rdata", h_rdata, pat(8));
        im_addr = 32'h20;
        step();
        old8 = pat(8);
        chk("t2_f2_ack",  h_ack,   0);
        chk("t3_fetch_new", im_data, {old8[31:16], 16'hBEEF});
        im_addr = 32'h24;
        step();
        chk("t2_f3_ack",  h_ack,   0);
        chk("t2_f3_data", im_data, pat(9));
        im_addr = 32'h28;
        step();
        chk("t2_f4_ack",   h_ack,    0);
        chk("t2_f4_valid", im_valid, 1);
        chk("t2_f4_data",  im_data,  pat(10));
        im_addr = 32'h2C;
        #1;
        chk("t2_h_addr", mem_addr, 14'h40);
        step();
        chk("t2_ack",   h_ack,    1);
        chk("t2_gap",   im_valid, 0);
        chk("t2_rdata", h_rdata,  pat(14'h40));
        h_req = 1'b0;
        #1;
        chk("t2_resume_addr", mem_addr, 14'hB);
        step();
        chk("t2_resume_valid", im_valid, 1);
        chk("t2_resume_data",  im_data,  pat(11));
        chk("t2_ack_low",      h_ack,    0);
        chk("t2_rdata_held",   h_rdata,  pat(14'h40));

        // 4: halted core, eight back-to-back host writes
        core_halt = 1'b1;
        h_req = 1'b1; h_we = 1'b1; h_be = 4'hF;
        for (int k = 0; k < 8; k++) begin
            h_addr  = 32'h200 + 32'(4 * k);
            h_wdata = 32'hC0DE_0000 + 32'(k);
            step();
            chk($sformatf("t4_ack%0d", k),   h_ack,    1);
            chk($sformatf("t4_valid%0d", k), im_valid, 0);
            chk($sformatf("t4_old%0d", k),   h_rdata,  pat(32'h80 + k));
        end

        // 6: upper address bits are ignored
        h_we = 1'b0;
        wide_addr = 33'h1_0000_0004;
        h_addr = wide_addr[31:0];
        step();
        chk("t6_ack",   h_ack,   1);
        chk("t6_alias", h_rdata, pat(1));
        h_addr = 32'h204;
        step();
        chk("t4_readback", h_rdata, 32'hC0DE_0001);
        h_addr = 32'h0001_0200;
        step();
        chk("t6_alias_hi", h_rdata, 32'hC0DE_0000);
        h_req = 1'b0;
        step();
        chk("t4_idle_ack",   h_ack,    0);
        chk("t4_idle_valid", im_valid, 0);
        core_halt = 1'b0;
        im_addr = 32'h21C;
        step();
        chk("t4_fetch_valid", im_valid, 1);
        chk("t4_fetch_data",  im_data,  32'hC0DE_0007);

        // 5: reset arrives while a host write is being granted
        core_halt = 1'b1;
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h8; h_wdata = 32'h0BAD_F00D; h_be = 4'hF;
        #1;
        chk("t5_we_before", mem_we, 4'hF);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", im_valid, 0);
        chk("t5_async_ack",   h_ack,    0);
        chk("t5_async_rdata", h_rdata,  0);
        chk("t5_async_we",    mem_we,   0);
        step();
        chk("t5_no_ack", h_ack, 0);
        rst_n = 1'b1;
        h_req = 1'b0; h_we = 1'b0; core_halt = 1'b0; im_addr = 32'h0;
        step();
        chk("t5_fetch_valid", im_valid, 1);
        chk("t5_fetch_data",  im_data,  pat(0));
        h_req = 1'b1; h_addr = 32'h8;
        step();
        chk("t5_reack",     h_ack,   1);
        chk("t5_not_wrote", h_rdata, pat(2));
        h_req = 1'b0;
        step();
        chk("t5_ack_low", h_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
